// File: rtl/sdram_uart_pkg.sv
// Shared types and constants for the SDRAM read-FIFO to UART drain path.
// The UART_PARITY_EN macro selects the 11-bit frame with an even parity bit.
// The default build uses the 10-bit 8N1 frame.
package sdram_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        POP,
        LATCH,
        SEND_HI,
        SEND_LO,
        FIN
    } state_t;

    localparam int CLK_FREQ_HZ  = 50000000;
    localparam int BAUD_RATE    = 9600;
    localparam int BAUD_CNT_MAX = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BAUD_CNT_W   = $clog2(BAUD_CNT_MAX);

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter.
// The frame is a start bit, then D0..D7 LSB first, then an even parity bit
// when UART_PARITY_EN is defined, then a stop bit.
// tx is registered. The start bit appears one cycle after byte_load.
// byte_done pulses for one cycle when the stop bit has finished.
module uart_byte_tx #(
    parameter int BAUD_CNT_MAX = sdram_uart_pkg::BAUD_CNT_MAX
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       byte_load,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       byte_done,
    output logic       byte_busy
);
    import sdram_uart_pkg::*;

    localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] frame;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;

    // Serialised frame, bit 0 first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Load a frame when idle, then shift one bit out per baud period.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            frame     <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            byte_done <= 1'b0;
            byte_busy <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!byte_busy) begin
                if (byte_load) begin
                    frame     <= build_frame(byte_data);
                    tx        <= 1'b0;
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                    byte_busy <= 1'b1;
                end
            end else if (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                    byte_busy <= 1'b0;
                    byte_done <= 1'b1;
                    tx        <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    tx      <= frame[1];
                    frame   <= {1'b1, frame[FRAME_BITS-1:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_rd_uart_tx.sv
// Drains bursts of DATA_NUM 16-bit words from sdram_top's read FIFO.
// Each word is sent on the UART as two bytes, high byte first.
// The UART frame is 8N1 by default. It adds an even parity bit when
// UART_PARITY_EN is defined.
// read_valid is driven low once the burst is buffered, so the SDRAM side
// holds off refilling until the next start.
module sdram_rd_uart_tx #(
    parameter int DATA_NUM     = 10,
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  rd_fifo_num,
    input  logic [15:0] rd_fifo_rd_data,
    output logic        rd_fifo_rd_req,
    output logic        read_valid,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    import sdram_uart_pkg::*;

    localparam int WCNT_W = $clog2(DATA_NUM + 1);

    state_t            state;
    logic [WCNT_W-1:0] word_cnt;
    logic [15:0]       word_reg;
    logic              byte_load;
    logic [7:0]        byte_data;
    logic              byte_done;
    logic              byte_busy;

    // The FIFO is non-showahead. The pop issues in POP so the data is valid in LATCH.
    // An empty FIFO holds the pop off.
    assign rd_fifo_rd_req = (state == POP) && (rd_fifo_num != '0);
    assign byte_data      = (state == SEND_LO) ? word_reg[7:0] : word_reg[15:8];

    // Burst sequencing: fill gate, pop, latch, then two bytes per word.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            word_reg   <= '0;
            byte_load  <= 1'b0;
            read_valid <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            byte_load <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= WAIT_FILL;
                        busy       <= 1'b1;
                        read_valid <= 1'b1;
                        word_cnt   <= '0;
                    end
                end
                WAIT_FILL: begin
                    if (rd_fifo_num >= 10'(DATA_NUM)) begin
                        read_valid <= 1'b0;
                        state      <= POP;
                    end
                end
                POP: begin
                    if (rd_fifo_num != '0) state <= LATCH;
                end
                LATCH: begin
                    word_reg  <= rd_fifo_rd_data;
                    word_cnt  <= word_cnt + 1'b1;
                    byte_load <= 1'b1;
                    state     <= SEND_HI;
                end
                SEND_HI: begin
                    if (byte_done) begin
                        byte_load <= 1'b1;
                        state     <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (byte_done)
                        state <= (word_cnt == WCNT_W'(DATA_NUM)) ? FIN : POP;
                end
                FIN: begin
                    if (!byte_busy) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_CNT_MAX (BAUD_CNT_MAX)
    ) u_byte_tx (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .byte_load (byte_load),
        .byte_data (byte_data),
        .tx        (tx),
        .byte_done (byte_done),
        .byte_busy (byte_busy)
    );

endmodule
